// File: rtl/lsu_misalign_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_misalign_seq
//  Description : Load/store sequencer that splits misaligned word and half
//                accesses into two word-aligned bus transactions and merges
//                the returned load data.
//  Ports       : clk_i/rst_i            clock, async active-high reset
//                lsu_*_i                request from the ID/EX pipeline
//                adder_result_ex_i      ALU address (first / incremented)
//                data_*                 word-aligned data bus (req/gnt/rvalid)
//                addr_incr_req_o        ALU operand-A select for phase 2
//                addr_last_o            byte address of the first phase
//                lsu_*_o                completion, load data, error
//                busy_o                 high whenever not IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_misalign_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic        addr_incr_req_o,
    output logic [31:0] addr_last_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_rdata_valid_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rdata_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GNT1  = 3'd1,
        RVAL1 = 3'd2,
        GNT2  = 3'd3,
        RVAL2 = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_last_q, wdata_q, rdata_q;
    logic [1:0]  type_q;
    logic        we_q, sext_q, split_q;

    logic        is_idle, latch_en, rdata_en, resp_valid, phase2, split_d;
    logic [1:0]  off, typ;
    logic        we_eff;
    logic [31:0] wdata_eff;
    logic [4:0]  sh;
    logic [5:0]  sh_inv;
    logic [31:0] x, rdata_ext;

    assign is_idle  = (state_q == IDLE);
    assign latch_en = is_idle & lsu_req_i;
    assign phase2   = (state_q == GNT2) || (state_q == RVAL2);

    // In IDLE the request is issued in the same cycle it arrives, so the bus
    // controls come straight from the inputs; afterwards from the latches.
    assign off       = is_idle ? adder_result_ex_i[1:0] : addr_last_q[1:0];
    assign typ       = is_idle ? lsu_type_i   : type_q;
    assign we_eff    = is_idle ? lsu_we_i     : we_q;
    assign wdata_eff = is_idle ? lsu_wdata_i  : wdata_q;
    assign sh        = {off, 3'b000};
    assign sh_inv    = 6'd32 - {1'b0, sh};

    always_comb begin
        split_d = 1'b0;
        if (lsu_type_i == 2'b00)      split_d = (adder_result_ex_i[1:0] != 2'b00);
        else if (lsu_type_i == 2'b01) split_d = (adder_result_ex_i[1:0] == 2'b11);
    end

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d         = state_q;
        data_req_o      = 1'b0;
        addr_incr_req_o = 1'b0;
        resp_valid      = 1'b0;
        rdata_en        = 1'b0;
        case (state_q)
            IDLE: begin
                data_req_o = lsu_req_i;
                if (lsu_req_i) state_d = data_gnt_i ? RVAL1 : GNT1;
            end
            GNT1: begin
                data_req_o = 1'b1;
                if (data_gnt_i) state_d = RVAL1;
            end
            RVAL1: begin
                if (data_rvalid_i) begin
                    rdata_en = 1'b1;
                    if (split_q && !data_err_i) begin
                        state_d = GNT2;
                    end else begin
                        resp_valid = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            GNT2: begin
                addr_incr_req_o = 1'b1;
                data_req_o      = 1'b1;
                if (data_gnt_i) state_d = RVAL2;
            end
            RVAL2: begin
                addr_incr_req_o = 1'b1;
                if (data_rvalid_i) begin
                    resp_valid = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset forces IDLE asynchronously; also mask a pending lsu_req_i so
        // the bus request drops in the very cycle reset is asserted.
        data_req_o = data_req_o & ~rst_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_last_q <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            type_q      <= 2'b00;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            split_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                addr_last_q <= adder_result_ex_i;
                wdata_q     <= lsu_wdata_i;
                type_q      <= lsu_type_i;
                we_q        <= lsu_we_i;
                sext_q      <= lsu_sign_ext_i;
                split_q     <= split_d;
            end
            if (rdata_en) rdata_q <= data_rdata_i;
        end
    end

    // ------------------------------------------------------------ bus side
    assign data_addr_o = (is_idle || state_q == GNT2)
                       ? {adder_result_ex_i[31:2], 2'b00}
                       : {addr_last_q[31:2], 2'b00};
    assign data_we_o   = we_eff;
    // Rotate left by 8*o; the right-shift term vanishes when o = 0.
    assign data_wdata_o = (wdata_eff << sh) | (wdata_eff >> sh_inv);

    always_comb begin
        data_be_o = 4'b0000;
        if (phase2) begin
            data_be_o = (typ == 2'b00) ? (4'b1111 >> (3'd4 - {1'b0, off})) : 4'b0001;
        end else begin
            case (typ)
                2'b00:   data_be_o = 4'b1111 << off;
                2'b01:   data_be_o = 4'b0011 << off;
                default: data_be_o = 4'b0001 << off;
            endcase
        end
    end

    // ------------------------------------------------------------ load side
    // Split result is ({rdata, rdata_q} >> 8*o)[31:0] written as two shifts.
    assign x = (state_q == RVAL2)
             ? ((rdata_q >> sh) | (data_rdata_i << sh_inv))
             : (data_rdata_i >> sh);

    always_comb begin
        case (type_q)
            2'b00:   rdata_ext = x;
            2'b01:   rdata_ext = {{16{sext_q & x[15]}}, x[15:0]};
            default: rdata_ext = {{24{sext_q & x[7]}}, x[7:0]};
        endcase
    end

    assign lsu_resp_valid_o  = resp_valid;
    assign lsu_rdata_valid_o = resp_valid & ~we_q;
    assign lsu_err_o         = resp_valid & data_err_i;
    assign lsu_rdata_o       = (resp_valid & ~we_q) ? rdata_ext : 32'd0;
    assign addr_last_o       = addr_last_q;
    assign busy_o            = ~is_idle;

endmodule
`default_nettype wire

// File: doc/lsu_misalign_seq.md
LSU_MISALIGN_SEQ -- requirements
Module: lsu_misalign_seq

Interface
REQ-001 Parameters: none; data bus and address width are fixed at 32 bits.
REQ-002 clk_i  in  1  single clock, all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 lsu_req_i  in  1  load/store request from the ID/EX pipeline, sampled only in IDLE.
REQ-005 lsu_we_i  in  1  1 = store, 0 = load.
REQ-006 lsu_type_i  in  2  00 = word, 01 = half, 10/11 = byte.
REQ-007 lsu_sign_ext_i  in  1  sign-extend half/byte load data.
REQ-008 lsu_wdata_i  in  32  store data, right-aligned.
REQ-009 adder_result_ex_i  in  32  ALU address result: the first address in IDLE, ALU-incremented address in phase 2.
REQ-010 data_req_o / data_gnt_i  out/in  1/1  bus request and grant.
REQ-011 data_addr_o  out  32  word-aligned bus address (bits [1:0] = 00).
REQ-012 data_we_o, data_be_o, data_wdata_o  out  1, 4, 32  bus write enable, byte enables, write data.
REQ-013 data_rvalid_i, data_err_i, data_rdata_i  in  1, 1, 32  bus response.
REQ-014 addr_incr_req_o  out  1  selects addr_last_o as the ALU operand A for the phase-2 address.
REQ-015 addr_last_o  out  32  byte address of the current/last first-phase access.
REQ-016 lsu_resp_valid_o, lsu_rdata_valid_o, lsu_err_o, lsu_rdata_o  out  1, 1, 1, 32  access completion, load data valid, bus error, load result.
REQ-017 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-018 States SHALL be IDLE, GNT1, RVAL1, GNT2, RVAL2. The request is split when word offset o = addr[1:0] is non-zero, or when half offset o = 3. Bytes are never split.
REQ-019 IDLE: data_req_o = lsu_req_i and data_addr_o = {adder_result_ex_i[31:2],2'b00}. When lsu_req_i = 1, latch addr_last_o, we, type, sign_ext, wdata and the split flag. Next state: RVAL1 if data_gnt_i, else GNT1.
REQ-020 GNT1: data_req_o = 1 with the latched address and controls held stable. On data_gnt_i, go to RVAL1.
REQ-021 RVAL1: on data_rvalid_i, go to GNT2 if split and no data_err_i. Otherwise complete and go to IDLE. On the phase-1 rvalid, store data_rdata_i in rdata_q.
REQ-022 GNT2: addr_incr_req_o = 1, data_req_o = 1, data_addr_o = {adder_result_ex_i[31:2],2'b00}. On data_gnt_i, go to RVAL2.
REQ-023 RVAL2: addr_incr_req_o = 1. On data_rvalid_i, complete and go to IDLE.
REQ-024 addr_incr_req_o SHALL be 0 in IDLE, GNT1 and RVAL1.
REQ-025 Byte enables, phase 1:
- word: 4'b1111 << o (truncated to 4 bits)
- half: 4'b0011 << o (truncated)
- byte: 4'b0001 << o
REQ-026 Byte enables, phase 2:
- word: 4'b1111 >> (4-o)
- half: 4'b0001
REQ-027 data_wdata_o SHALL be the latched wdata rotated left by 8*o in both phases. data_we_o SHALL be the latched we.
REQ-028 Load result:
- aligned: x = data_rdata_i >> 8*o
- split: x = ({data_rdata_i, rdata_q} >> 8*o)[31:0]
- half: zero- or sign-extend x[15:0]; byte: zero- or sign-extend x[7:0], per latched sign_ext.
REQ-029 Completion cycle (final rvalid): lsu_resp_valid_o = 1 for exactly one cycle. lsu_rdata_valid_o = lsu_resp_valid_o & ~we. lsu_err_o = data_err_i. lsu_rdata_o = 0 except in the load completion cycle.
REQ-030 A phase-1 error on a split access SHALL abort phase 2 and complete immediately with lsu_err_o = 1. addr_last_o keeps the first address.
REQ-031 Bus timing:
- data_rvalid_i arrives no earlier than the cycle after its grant.
- rvalid/gnt in states not expecting them SHALL be ignored.
- lsu_req_i while busy_o = 1 SHALL be ignored.
- At most one bus transaction is outstanding.
REQ-032 Latency: with gnt at request and rvalid in the next cycle, aligned access = 2 cycles and split access = 4 cycles (request to completion inclusive).

Reset
REQ-033 While rst_i = 1, outputs and registers SHALL clear asynchronously: state = IDLE, addr_last_o = 0, rdata_q = 0, busy_o = 0, addr_incr_req_o = 0, lsu_resp_valid_o = lsu_rdata_valid_o = lsu_err_o = 0, lsu_rdata_o = 0.
REQ-034 Reset mid-access SHALL drop data_req_o immediately and abandon the transaction with no response.

Verification
REQ-035 Aligned word load at 0x1000, gnt immediate, rvalid next cycle with 0xDEADBEEF -> addr 0x1000, be 1111, rdata 0xDEADBEEF, addr_incr_req_o never 1.
REQ-036 Word load at 0x1002, phase-1 rdata 0x11223344, phase-2 rdata 0x55667788 -> the bench checks:
- phase 1: addr 0x1000, be 1100
- phase 2: addr 0x1004, be 0011, addr_incr_req_o = 1 in GNT2/RVAL2
- addr_last_o = 0x1002
- result 0x77881122
REQ-037 Half store at 0x2003, wdata 0x0000ABCD -> phase 1: 0x2000, be 1000, wdata 0xCD0000AB. Phase 2: 0x2004, be 0001, same wdata.
REQ-038 Byte load at 0x3001 with rdata 0x00008000 -> signed 0xFFFFFF80, unsigned 0x00000080.
REQ-039 Split word load at 0x4001 with data_err_i on the phase-1 rvalid -> no second data_req_o, lsu_err_o = 1 for one cycle, addr_last_o = 0x4001.
REQ-040 rst_i asserted in GNT2 with gnt withheld -> data_req_o, addr_incr_req_o, busy_o = 0 in the same cycle, no lsu_resp_valid_o afterwards.
